// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for serial_addsub.
// master drives the request side, slave is the arithmetic core.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: LSB-first, DIGIT bits per clock, registered carry.
// Optional macro SERIAL_ADDSUB_SAT_EN clamps sum on signed overflow.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus_if
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] sum_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
`ifdef SERIAL_ADDSUB_SAT_EN
    logic             a_sign_q;
`endif

    logic [DIGIT-1:0] dig_sum_d;
    logic             dig_cout_d;
    logic             dig_cmsb_d;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d;
    logic             last_digit;

    // One DIGIT-bit ripple slice on the low digit of the shifting operands
    always_comb begin
        logic c;
        c          = carry_q;
        dig_sum_d  = '0;
        dig_cmsb_d = carry_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            dig_cmsb_d   = c;
            dig_sum_d[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        dig_cout_d = c;
    end

    // New digit enters at the top so the shadow ends LSB-aligned after N steps
    assign shadow_d   = (shadow_q >> DIGIT) | (WIDTH'(dig_sum_d) << (WIDTH - DIGIT));
    assign ovf_d      = dig_cmsb_d ^ dig_cout_d;
    assign last_digit = (cnt_q == CW'(N - 1));

    always_comb begin
        result_d = shadow_d;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (ovf_d) begin
            result_d = {a_sign_q, {(WIDTH - 1){~a_sign_q}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            sum_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
            a_sign_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus_if.start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        a_q     <= bus_if.a;
                        b_q     <= bus_if.b ^ {WIDTH{bus_if.mode}};
                        carry_q <= bus_if.cin ^ bus_if.mode;
`ifdef SERIAL_ADDSUB_SAT_EN
                        a_sign_q <= bus_if.a[WIDTH-1];
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    shadow_q <= shadow_d;
                    carry_q  <= dig_cout_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_digit) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= result_d;
                        cout_q  <= dig_cout_d;
                        ovf_q   <= ovf_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.busy = busy_q;
    assign bus_if.done = done_q;
    assign bus_if.sum  = sum_q;
    assign bus_if.cout = cout_q;
    assign bus_if.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: 8-bit/1-bit-digit and 16-bit/4-bit-digit instances,
// arithmetic reference model plus directed vectors with literal expectations.
module tb_serial_addsub;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_addsub_if #(.WIDTH(8))  if8 ();
    serial_addsub_if #(.WIDTH(16)) if16 ();

    serial_addsub #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus_if(if8));
    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus_if(if16));

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [7:0] OVF_ADD_SUM = 8'h7F;
    localparam logic [7:0] OVF_SUB_SUM = 8'h80;
`else
    localparam logic [7:0] OVF_ADD_SUM = 8'h80;
    localparam logic [7:0] OVF_SUB_SUM = 8'h7F;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Whole-word arithmetic reference for a w-bit operation
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic m, input logic c,
                                  output logic [15:0] s, output logic co, output logic ov);
        logic [31:0] mask, bb, full;
        mask = (32'd1 << w) - 32'd1;
        bb   = (m ? ~{16'h0, b} : {16'h0, b}) & mask;
        full = {16'h0, a} + bb + 32'(c ^ m);
        s    = 16'(full & mask);
        co   = full[w];
        ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (ov) s = a[w-1] ? 16'(32'd1 << (w - 1)) : 16'(mask >> 1);
`endif
    endfunction

    // Cycle-level expectation: results appear N edges after an accepted start
    logic [7:0]  m8_sum,  p8_sum;
    logic [15:0] m16_sum, p16_sum;
    logic m8_busy, m8_done, m8_cout, m8_ovf, p8_cout, p8_ovf;
    logic m16_busy, m16_done, m16_cout, m16_ovf, p16_cout, p16_ovf;
    int   m8_cnt, m16_cnt;

    always @(posedge clk or posedge rst) begin
        logic [15:0] s;
        logic co, ov;
        if (rst) begin
            m8_busy <= 1'b0; m8_done <= 1'b0; m8_sum <= '0; m8_cout <= 1'b0; m8_ovf <= 1'b0;
            m8_cnt  <= 0; p8_sum <= '0; p8_cout <= 1'b0; p8_ovf <= 1'b0;
        end else if (m8_cnt != 0) begin
            m8_cnt <= m8_cnt - 1;
            if (m8_cnt == 1) begin
                m8_busy <= 1'b0; m8_done <= 1'b1;
                m8_sum <= p8_sum; m8_cout <= p8_cout; m8_ovf <= p8_ovf;
            end
        end else begin
            m8_done <= 1'b0;
            m8_busy <= if8.start;
            if (if8.start) begin
                model(8, {8'h0, if8.a}, {8'h0, if8.b}, if8.mode, if8.cin, s, co, ov);
                p8_sum <= s[7:0]; p8_cout <= co; p8_ovf <= ov;
                m8_cnt <= 8;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        logic [15:0] s;
        logic co, ov;
        if (rst) begin
            m16_busy <= 1'b0; m16_done <= 1'b0; m16_sum <= '0; m16_cout <= 1'b0; m16_ovf <= 1'b0;
            m16_cnt  <= 0; p16_sum <= '0; p16_cout <= 1'b0; p16_ovf <= 1'b0;
        end else if (m16_cnt != 0) begin
            m16_cnt <= m16_cnt - 1;
            if (m16_cnt == 1) begin
                m16_busy <= 1'b0; m16_done <= 1'b1;
                m16_sum <= p16_sum; m16_cout <= p16_cout; m16_ovf <= p16_ovf;
            end
        end else begin
            m16_done <= 1'b0;
            m16_busy <= if16.start;
            if (if16.start) begin
                model(16, if16.a, if16.b, if16.mode, if16.cin, s, co, ov);
                p16_sum <= s; p16_cout <= co; p16_ovf <= ov;
                m16_cnt <= 4;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("cycle8",  {20'h0, if8.busy, if8.done, if8.cout, if8.ovf, if8.sum},
                           {20'h0, m8_busy, m8_done, m8_cout, m8_ovf, m8_sum});
            chk("cycle16", {12'h0, if16.busy, if16.done, if16.cout, if16.ovf, if16.sum},
                           {12'h0, m16_busy, m16_done, m16_cout, m16_ovf, m16_sum});
        end
    end

    task automatic wait_done8(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!if8.done && lat < 40) begin
            if (if8.busy) bc++;
            @(negedge clk);
            lat++;
        end
        lat = lat - 1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m, input logic c,
                       output int lat, output int bc);
        @(negedge clk);
        if8.a = a; if8.b = b; if8.mode = m; if8.cin = c; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8(lat, bc);
    endtask

    task automatic count_done8(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if8.done) n++;
        end
    endtask

    initial begin
        int lat, bc, n;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        if8.start = 1'b0;  if8.mode = 1'b0;  if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;
        if16.start = 1'b0; if16.mode = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset8", {20'h0, if8.busy, if8.done, if8.cout, if8.ovf, if8.sum}, 32'h0);

        op8(8'h05, 8'h03, 1'b0, 1'b0, lat, bc);
        chk("add_sum", 32'(if8.sum), 32'h08);
        chk("add_flags", {30'h0, if8.cout, if8.ovf}, 32'h0);
        chk("add_latency", 32'(lat), 32'd8);
        chk("add_busy_cycles", 32'(bc), 32'd8);
        @(negedge clk);
        chk("done_one_cycle", {31'h0, if8.done}, 32'h0);

        op8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bc);
        chk("wrap_sum", 32'(if8.sum), 32'h00);
        chk("wrap_flags", {30'h0, if8.cout, if8.ovf}, 32'h2);
        op8(8'hFF, 8'h00, 1'b0, 1'b1, lat, bc);
        chk("wrap_cin_sum", 32'(if8.sum), 32'h00);
        chk("wrap_cin_cout", {31'h0, if8.cout}, 32'h1);

        op8(8'h03, 8'h05, 1'b1, 1'b0, lat, bc);
        chk("sub_borrow_sum", 32'(if8.sum), 32'hFE);
        chk("sub_borrow_flags", {30'h0, if8.cout, if8.ovf}, 32'h0);
        op8(8'h05, 8'h03, 1'b1, 1'b1, lat, bc);
        chk("sub_bin_sum", 32'(if8.sum), 32'h01);
        chk("sub_bin_cout", {31'h0, if8.cout}, 32'h1);

        op8(8'h7F, 8'h01, 1'b0, 1'b0, lat, bc);
        chk("ovf_add_sum", 32'(if8.sum), 32'(OVF_ADD_SUM));
        chk("ovf_add_flags", {30'h0, if8.cout, if8.ovf}, 32'h1);
        op8(8'h80, 8'h01, 1'b1, 1'b0, lat, bc);
        chk("ovf_sub_sum", 32'(if8.sum), 32'(OVF_SUB_SUM));
        chk("ovf_sub_flags", {30'h0, if8.cout, if8.ovf}, 32'h3);

        // start pulsed during RUN must be dropped
        @(negedge clk);
        if8.a = 8'h10; if8.b = 8'h20; if8.mode = 1'b0; if8.cin = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (2) @(negedge clk);
        if8.a = 8'h55; if8.b = 8'h11; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8(lat, bc);
        chk("ignored_start_sum", 32'(if8.sum), 32'h30);
        count_done8(12, n);
        chk("ignored_start_no_done", 32'(n), 32'd0);

        // Reset in the 4th RUN cycle
        @(negedge clk);
        if8.a = 8'h40; if8.b = 8'h01; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("midrun_reset", {20'h0, if8.busy, if8.done, if8.cout, if8.ovf, if8.sum}, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        count_done8(12, n);
        chk("reset_no_done", 32'(n), 32'd0);

        op8(8'h22, 8'h11, 1'b0, 1'b0, lat, bc);
        chk("post_reset_sum", 32'(if8.sum), 32'h33);
        chk("post_reset_latency", 32'(lat), 32'd8);

        // start held high: one result every N+1 cycles
        @(negedge clk);
        if8.a = 8'h01; if8.b = 8'h01; if8.mode = 1'b0; if8.cin = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        wait_done8(lat, bc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if8.done && n < 40);
        if8.start = 1'b0;
        chk("held_start_period", 32'(n), 32'd9);
        chk("held_start_sum", 32'(if8.sum), 32'h02);
        repeat (12) @(negedge clk);
        chk("held_release_idle", {30'h0, if8.busy, if8.done}, 32'h0);

        // Wide digit instance
        @(negedge clk);
        if16.a = 16'h1234; if16.b = 16'h0FFF; if16.mode = 1'b0; if16.cin = 1'b0; if16.start = 1'b1;
        @(negedge clk);
        if16.start = 1'b0;
        lat = 1;
        while (!if16.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("wide_sum", 32'(if16.sum), 32'h2233);
        chk("wide_flags", {30'h0, if16.cout, if16.ovf}, 32'h0);
        chk("wide_latency", 32'(lat - 1), 32'd4);

        @(negedge clk);
        if16.a = 16'h0001; if16.b = 16'h0002; if16.mode = 1'b1; if16.start = 1'b1;
        @(negedge clk);
        if16.start = 1'b0;
        lat = 1;
        while (!if16.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("wide_sub_sum", 32'(if16.sum), 32'hFFFF);
        chk("wide_sub_flags", {30'h0, if16.cout, if16.ovf}, 32'h0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
